// File: rtl/easy_fifo_pkg.sv
// Shared types and helpers for the easy_fifo AXIS arbiter.
// Arbiter state encoding and source-index width calculation.
package easy_fifo_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_t;

  // Source index width: never narrower than one bit.
  function automatic int idw_calc(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/easy_fifo_axis_arb_if.sv
// AXIS bundle between NUM_SRC sources, the arbiter and the FIFO.
// master = arbiter side, slave = sources/FIFO side.
interface easy_fifo_axis_arb_if #(
  parameter int NUM_SRC = 4,
  parameter int DWIDTH  = 32
);
  import easy_fifo_pkg::*;

  localparam int IDW = idw_calc(NUM_SRC);

  logic [NUM_SRC*DWIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [DWIDTH-1:0]         m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic [IDW-1:0]            m_axis_tid;
  logic                      m_axis_tready;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    output m_axis_tid,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  m_axis_tid,
    output m_axis_tready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first requester after ptr, modulo N.
// Purely combinational.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                            req_i,
  input  logic [easy_fifo_pkg::idw_calc(N)-1:0]   ptr_i,
  output logic [easy_fifo_pkg::idw_calc(N)-1:0]   gnt_idx_o,
  output logic                                    gnt_any_o
);
  import easy_fifo_pkg::*;

  localparam int W = idw_calc(N);

  logic [W-1:0] idx;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/easy_fifo_axis_arb.sv
// Round-robin AXIS arbiter feeding one FIFO write port.
// Registered output, optional packet-level grant lock.
module easy_fifo_axis_arb #(
  parameter int NUM_SRC  = 4,
  parameter int DWIDTH   = 32,
  parameter int PKT_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  easy_fifo_axis_arb_if.master bus
);
  import easy_fifo_pkg::*;

  localparam int IDW = idw_calc(NUM_SRC);

  arb_state_t        state_q;
  logic [IDW-1:0]    gnt_q;
  logic [IDW-1:0]    ptr_q;
  logic [DWIDTH-1:0] data_q;
  logic              last_q;
  logic [IDW-1:0]    id_q;
  logic              valid_q;

  logic [IDW-1:0]     rr_idx;
  logic               rr_any;
  logic [IDW-1:0]     cur;
  logic               granted;
  logic               out_free;
  logic [NUM_SRC-1:0] ready;
  logic               xfer;
  logic [DWIDTH-1:0]  cur_data;
  logic               cur_last;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req_i     (bus.s_axis_tvalid),
    .ptr_i     (ptr_q),
    .gnt_idx_o (rr_idx),
    .gnt_any_o (rr_any)
  );

  assign out_free = ~valid_q | bus.m_axis_tready;

  // Locked grant overrides the round-robin pick.
  always_comb begin
    cur     = rr_idx;
    granted = rr_any;
    if (state_q == LOCKED) begin
      cur     = gnt_q;
      granted = 1'b1;
    end
  end

  // One-hot ready towards the current source only.
  always_comb begin
    ready = '0;
    if (granted & out_free & ~rst) ready[cur] = 1'b1;
  end

  assign xfer = |(ready & bus.s_axis_tvalid);

  // Select the current source's beat.
  always_comb begin
    cur_data = '0;
    cur_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur == IDW'(i)) begin
        cur_data = bus.s_axis_tdata[i*DWIDTH +: DWIDTH];
        cur_last = bus.s_axis_tlast[i];
      end
    end
  end

  // Grant FSM, round-robin pointer and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      gnt_q   <= '0;
      ptr_q   <= IDW'(NUM_SRC - 1);
      data_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= cur_data;
      last_q  <= cur_last;
      id_q    <= cur;
      valid_q <= 1'b1;
      if (PKT_MODE != 0) begin
        if (cur_last) begin
          state_q <= UNLOCKED;
          ptr_q   <= cur;
        end else begin
          state_q <= LOCKED;
          gnt_q   <= cur;
        end
      end else begin
        ptr_q <= cur;
      end
    end else if (bus.m_axis_tready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.s_axis_tready = ready;
  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tlast  = last_q;
  assign bus.m_axis_tid    = id_q;
  assign bus.m_axis_tvalid = valid_q;

endmodule

// File: tb/tb_easy_fifo_axis_arb.sv
// Bench for easy_fifo_axis_arb: directed scenarios plus random
// traffic against a cycle-level behavioural model and scoreboard.
module tb_easy_fifo_axis_arb;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NS*DW-1:0] s_tdata = '0;
  logic [NS-1:0]    s_tvalid = '0;
  logic [NS-1:0]    s_tlast = '0;
  logic             m_tready = 1'b1;

  easy_fifo_axis_arb_if #(.NUM_SRC(NS), .DWIDTH(DW)) bus1 ();
  easy_fifo_axis_arb_if #(.NUM_SRC(NS), .DWIDTH(DW)) bus0 ();

  assign bus1.s_axis_tdata  = s_tdata;
  assign bus1.s_axis_tvalid = s_tvalid;
  assign bus1.s_axis_tlast  = s_tlast;
  assign bus1.m_axis_tready = m_tready;
  assign bus0.s_axis_tdata  = s_tdata;
  assign bus0.s_axis_tvalid = s_tvalid;
  assign bus0.s_axis_tlast  = s_tlast;
  assign bus0.m_axis_tready = m_tready;

  easy_fifo_axis_arb #(.NUM_SRC(NS), .DWIDTH(DW), .PKT_MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  easy_fifo_axis_arb #(.NUM_SRC(NS), .DWIDTH(DW), .PKT_MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  bit sel;
  logic [NS-1:0] d_rdy;
  logic [DW-1:0] d_tdata;
  logic          d_tvalid;
  logic          d_tlast;
  logic [IW-1:0] d_tid;

  assign d_rdy    = sel ? bus0.s_axis_tready : bus1.s_axis_tready;
  assign d_tdata  = sel ? bus0.m_axis_tdata  : bus1.m_axis_tdata;
  assign d_tvalid = sel ? bus0.m_axis_tvalid : bus1.m_axis_tvalid;
  assign d_tlast  = sel ? bus0.m_axis_tlast  : bus1.m_axis_tlast;
  assign d_tid    = sel ? bus0.m_axis_tid    : bus1.m_axis_tid;

  typedef struct {
    logic [DW-1:0] d;
    bit            l;
    int            id;
    int            cyc;
  } beat_t;

  // model state
  bit            pkt;
  int            lock_src;
  int            ptr_m;
  bit            ov;
  bit            ol;
  logic [DW-1:0] od;
  int            oid;
  int            m_cur;
  logic [NS-1:0] m_rdy;

  // source state
  logic [DW:0]   srcq [NS][$];
  logic [DW:0]   exp_src [NS][$];
  bit            has [NS];
  logic [DW-1:0] cd [NS];
  bit            cl [NS];
  bit            gen;
  bit            rnd_gap;
  int            tr_mode;

  beat_t         olog[$];
  int            out_open;
  int            cyc;
  int            checks;
  int            errors;
  logic [NS-1:0] last_rdy;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int i, input logic [DW-1:0] d,
                           input bit l);
    srcq[i].push_back({l, d});
    exp_src[i].push_back({l, d});
  endtask

  function automatic void model_reset();
    lock_src = -1;
    ptr_m    = NS - 1;
    ov       = 1'b0;
    ol       = 1'b0;
    od       = '0;
    oid      = 0;
    out_open = -1;
  endfunction

  // Who may send now: the locked owner, else the first valid
  // source after the last grant winner.
  function automatic void model_comb();
    int j;
    m_rdy = '0;
    m_cur = -1;
    if (lock_src >= 0) m_cur = lock_src;
    else begin
      for (int k = 1; k <= NS; k++) begin
        j = (ptr_m + k) % NS;
        if (m_cur < 0 && s_tvalid[j]) m_cur = j;
      end
    end
    if (m_cur >= 0 && (!ov || m_tready)) m_rdy[m_cur] = 1'b1;
  endfunction

  task automatic log_out();
    logic [DW:0] e;
    olog.push_back('{d: od, l: ol, id: oid, cyc: cyc});
    checks++;
    if (exp_src[oid].size() == 0) begin
      errors++;
      $display("FAIL sb_avail: got beat %0h from src %0d, expected none",
               od, oid);
    end else begin
      e = exp_src[oid].pop_front();
      chk("sb_beat", {ol, od}, e);
    end
    if (pkt) begin
      if (out_open >= 0) chk("interleave", oid, out_open);
      out_open = ol ? -1 : oid;
    end
  endtask

  task automatic drive();
    logic [DW:0] b;
    int n;
    for (int i = 0; i < NS; i++) begin
      if (gen && !has[i] && srcq[i].size() == 0 &&
          $urandom_range(3) == 0) begin
        n = $urandom_range(4, 1);
        for (int k = 0; k < n; k++)
          push_beat(i, $urandom, k == n - 1);
      end
      if (!has[i] && srcq[i].size() > 0 &&
          (!rnd_gap || $urandom_range(3) != 0)) begin
        b = srcq[i].pop_front();
        cd[i] = b[DW-1:0];
        cl[i] = b[DW];
        has[i] = 1'b1;
      end
      s_tvalid[i] = has[i];
      s_tlast[i]  = has[i] ? cl[i] : 1'b0;
      s_tdata[i*DW +: DW] = has[i] ? cd[i] : DW'($urandom);
    end
    case (tr_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = ($urandom_range(3) != 0);
      default: m_tready = 1'b1;
    endcase
  endtask

  // One clock: check ready, advance model, check registered outputs.
  task automatic step();
    bit stall;
    logic [DW-1:0] pd;
    #1;
    model_comb();
    last_rdy = d_rdy;
    chk("s_tready", d_rdy, m_rdy);
    if (ov && !m_tready) chk("rdy_block", d_rdy, 0);
    stall = ov && !m_tready;
    pd = od;
    @(posedge clk);
    cyc++;
    if (ov && m_tready) log_out();
    if (m_cur >= 0 && m_rdy[m_cur] && s_tvalid[m_cur]) begin
      ov  = 1'b1;
      od  = cd[m_cur];
      ol  = cl[m_cur];
      oid = m_cur;
      has[m_cur] = 1'b0;
      if (!pkt) ptr_m = m_cur;
      else if (cl[m_cur]) begin
        lock_src = -1;
        ptr_m = m_cur;
      end else lock_src = m_cur;
    end else if (m_tready) ov = 1'b0;
    @(negedge clk);
    chk("m_tvalid", d_tvalid, ov);
    chk("m_tdata", d_tdata, od);
    chk("m_tlast", d_tlast, ol);
    chk("m_tid", d_tid, oid);
    if (stall) chk("stable", d_tdata, pd);
    drive();
  endtask

  task automatic run_until(input string nm, input int n, input int budget);
    int b = 0;
    while (olog.size() < n && b < budget) begin
      step();
      b++;
    end
    chk(nm, olog.size(), n);
  endtask

  // Asynchronous reset off the clock edge; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", d_tvalid, 0);
    chk("arst_tdata", d_tdata, 0);
    chk("arst_tlast", d_tlast, 0);
    chk("arst_tid", d_tid, 0);
    chk("arst_tready", d_rdy, 0);
    for (int i = 0; i < NS; i++) begin
      has[i] = 1'b0;
      srcq[i].delete();
      exp_src[i].delete();
    end
    s_tvalid = '0;
    s_tlast  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    drive();
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NS; i++)
      p += srcq[i].size() + exp_src[i].size() + int'(has[i]);
    return p + int'(ov);
  endfunction

  task automatic random_phase(input int ncyc);
    int b = 0;
    gen = 1'b1;
    rnd_gap = 1'b1;
    tr_mode = 2;
    for (int c = 0; c < ncyc; c++) step();
    gen = 1'b0;
    rnd_gap = 1'b0;
    tr_mode = 0;
    while (pending() != 0 && b < 300) begin
      step();
      b++;
    end
    chk("drain", pending(), 0);
  endtask

  initial begin
    int c0;
    checks = 0;
    errors = 0;
    cyc = 0;
    gen = 1'b0;
    rnd_gap = 1'b0;
    tr_mode = 0;
    sel = 1'b0;
    pkt = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // single-beat packets from every source, in order 0..3
    olog.delete();
    for (int i = 0; i < NS; i++) push_beat(i, DW'('hA0 + i), 1'b1);
    drive();
    c0 = cyc;
    run_until("t1_count", 4, 20);
    for (int i = 0; i < olog.size(); i++) begin
      chk("t1_data", olog[i].d, 'hA0 + i);
      chk("t1_tid", olog[i].id, i);
      chk("t1_cycle", olog[i].cyc, c0 + 2 + i);
    end

    // two concurrent 3-beat packets, never interleaved
    olog.delete();
    for (int k = 0; k < 3; k++) begin
      push_beat(1, DW'('h11 + k), k == 2);
      push_beat(2, DW'('h21 + k), k == 2);
    end
    drive();
    run_until("t2_count", 6, 30);
    for (int i = 0; i < olog.size(); i++) begin
      chk("t2_data", olog[i].d, (i < 3) ? 'h11 + i : 'h21 + i - 3);
      chk("t2_tid", olog[i].id, (i < 3) ? 1 : 2);
      chk("t2_last", olog[i].l, (i % 3) == 2);
    end

    // lone source with back-pressure toggling
    olog.delete();
    for (int k = 0; k < 8; k++) push_beat(3, DW'('hD0 + k), k == 7);
    tr_mode = 1;
    drive();
    run_until("t3_count", 8, 40);
    tr_mode = 0;
    for (int i = 0; i < olog.size(); i++) begin
      chk("t3_data", olog[i].d, 'hD0 + i);
      chk("t3_tid", olog[i].id, 3);
    end

    // locked owner stalls; the other source must wait
    olog.delete();
    push_beat(0, DW'('hE0), 1'b0);
    push_beat(1, DW'('hF0), 1'b1);
    drive();
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_lock_hold", last_rdy[1], 0);
    end
    for (int k = 1; k < 4; k++) push_beat(0, DW'('hE0 + k), k == 3);
    drive();
    run_until("t4_count", 5, 30);
    for (int i = 0; i < olog.size(); i++) begin
      chk("t4_data", olog[i].d, (i < 4) ? 'hE0 + i : 'hF0);
      chk("t4_tid", olog[i].id, (i < 4) ? 0 : 1);
    end

    // reset mid-packet, then source 0 has first priority
    for (int k = 0; k < 4; k++) push_beat(2, DW'('h31 + k), k == 3);
    drive();
    step();
    step();
    do_reset();
    olog.delete();
    push_beat(3, DW'('h43), 1'b1);
    push_beat(0, DW'('h40), 1'b1);
    drive();
    run_until("t5_count", 2, 10);
    if (olog.size() == 2) begin
      chk("t5_first", olog[0].id, 0);
      chk("t5_second", olog[1].id, 3);
    end

    random_phase(1500);

    // per-beat arbitration: strict alternation, no bubbles
    sel = 1'b1;
    pkt = 1'b0;
    do_reset();
    olog.delete();
    for (int k = 0; k < 8; k++) begin
      push_beat(0, DW'('h500 + k), $urandom_range(1));
      push_beat(1, DW'('h600 + k), $urandom_range(1));
    end
    drive();
    run_until("t6_count", 16, 40);
    for (int i = 0; i < olog.size(); i++) begin
      chk("t6_tid", olog[i].id, i % 2);
      chk("t6_cycle", olog[i].cyc, olog[0].cyc + i);
    end

    random_phase(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d",
             errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/easy_fifo_axis_arb.md
# easy_fifo_axis_arb

Round-robin AXI-Stream arbiter that shares one FIFO write port between NUM_SRC requesters. Sits directly in front of an easy_fifo AXIS FIFO: merges the source streams into one registered output stream, tags every beat with its source index, and optionally holds the grant for a whole packet (until tlast) so packets are never interleaved in the FIFO.

## Interface
- NUM_SRC, 4: number of requesting streams, 2..16.
- DWIDTH, 32: data width per stream.
- PKT_MODE, 1: 1 = grant held until the tlast beat is accepted; 0 = re-arbitrate after every beat.
- IDW, derived: max(1, $clog2(NUM_SRC)); not overridable.

- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- s_axis_tdata  input  NUM_SRC*DWIDTH  source data, source i at [i*DWIDTH +: DWIDTH].
- s_axis_tvalid  input  NUM_SRC  per-source valid.
- s_axis_tlast  input  NUM_SRC  per-source end of packet.
- s_axis_tready  output  NUM_SRC  per-source ready; at most one bit high.
- m_axis_tdata  output  DWIDTH  merged data (to FIFO).
- m_axis_tvalid  output  1  merged valid.
- m_axis_tlast  output  1  merged last.
- m_axis_tid  output  IDW  index of the source of the current beat.
- m_axis_tready  input  1  FIFO ready (FIFO not full).

## Operation
- State enum: UNLOCKED, LOCKED. Registers: state, held grant gnt_q[IDW], round-robin pointer ptr_q[IDW], output register (data, last, id, valid).
- out_free = ~m_axis_tvalid | m_axis_tready.
- UNLOCKED: cur = first i with s_axis_tvalid[i], searching ptr_q+1, ptr_q+2, … modulo NUM_SRC. No valid: no grant; every s_axis_tready bit is 0.
- LOCKED: cur = gnt_q; other sources' valids are ignored.
- s_axis_tready[i] = (i == cur) & granted & out_free. Transfer = s_axis_tvalid[cur] & s_axis_tready[cur].
- On a transfer: load the output register with data, last and id = cur, and set valid. On a transfer, set ptr_q = cur when the beat ends a grant: any beat if PKT_MODE=0; a tlast beat if PKT_MODE=1.
- PKT_MODE=1, transfer with tlast=0: state -> LOCKED, gnt_q = cur. Transfer with tlast=1: state -> UNLOCKED. A single-beat packet never enters LOCKED.
- PKT_MODE=0: always UNLOCKED; s_axis_tlast is passed through.
- Output register with m_axis_tready=1 and no new transfer: clear valid. Data, last and id hold their values.
- LOCKED with the locked source's tvalid=0: hold LOCKED and wait. Do not re-arbitrate.
- Reset, which may be asserted mid-packet: asynchronously forces state=UNLOCKED, ptr_q=NUM_SRC-1 (so source 0 has first priority), gnt_q=0, m_axis_tdata/tlast/tid/tvalid=0, and all s_axis_tready bits to 0.
- A partial packet already in the output register is dropped by reset.

## Timing
- Latency: one cycle from a source transfer to m_axis_tvalid.
- Throughput: one beat per cycle sustained, including back-to-back grants to different sources; there are no arbitration bubbles.
- Combinational paths: s_axis_tvalid -> s_axis_tready and m_axis_tready -> s_axis_tready. Both are legal under AXIS.
- There is no path from any input to the m_axis_* outputs; they come only from registers.
- AXIS rule: once m_axis_tvalid is high, data, last and id stay stable until accepted.
- Simultaneous accept on m_axis and new transfer in the same cycle: the register reloads and valid stays 1.

## Structure
- Shared package easy_fifo_pkg holds:
  - the arb_state_t enum (UNLOCKED, LOCKED);
  - the function for the IDW width calculation.
- Sub-module rr_arbiter #(N) computes the rotating-priority pick. Purely combinational.
  - Inputs: req[N] and ptr.
  - Outputs: gnt_idx and gnt_any.
- The top module holds the FSM, the pointer and the output register.

## Test plan
- Reset, then sources 0..3 each present one single-beat packet (tdata 0xA0..0xA3) with m_axis_tready=1: output is 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, tid 0..3, first beat one cycle after the first transfer.
- PKT_MODE=1, sources 1 and 2 each send a 3-beat packet concurrently: all 3 beats of source 1 appear, then all 3 of source 2, with no interleaving; tlast appears on beats 3 and 6.
- Only source 3 valid, continuous for 8 beats, with m_axis_tready toggling 1,0,1,0: no beat lost or duplicated; m_axis_tdata stable while tready=0; s_axis_tready[3] low whenever the register is full and not accepted.
- LOCKED on source 0 after beat 1 of 4, source 0 tvalid low for 5 cycles while source 1 is valid: s_axis_tready[1] stays 0; source 0 resumes and completes, then source 1 is granted.
- PKT_MODE=0, sources 0 and 1 continuously valid: tid alternates 0,1,0,1 with one beat per cycle.
- rst pulsed asynchronously (not clock-aligned) mid-packet: all outputs 0 immediately; after release, source 0 has first priority and the FSM is UNLOCKED.
